serial_subtractor: RTL and testbench

Multi-cycle, bit-serial subtractor computing x − y − bin over WIDTH-bit unsigned/two's-complement operands, one bit per clock, LSB first. It is the area-lean counterpart to the team's combinational ripple-carry adder: same bit-level arithmetic, run in the subtract direction with a single borrow flip-flop in place of the carry chain. It is used where a WIDTH-cycle latency is acceptable in exchange for one full-subtractor cell. A start/busy/done handshake connects it to control logic.

---
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: x - y - bin, one bit per clock, LSB first.
// A single borrow flop replaces the ripple chain; start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             x_msb;
  logic             y_msb;
  logic             d;
  logic             nb;

  // One full-subtractor cell
  assign d  = xs[0] ^ ys[0] ^ borrow;
  assign nb = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & borrow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      xs     <= '0;
      ys     <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      x_msb  <= 1'b0;
      y_msb  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            xs     <= x;
            ys     <= y;
            borrow <= bin;
            cnt    <= '0;
            x_msb  <= x[WIDTH-1];
            y_msb  <= y[WIDTH-1];
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res    <= {d, res[WIDTH-1:1]};
          xs     <= xs >> 1;
          ys     <= ys >> 1;
          borrow <= nb;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // d is the result MSB on the final bit
            diff  <= {d, res[WIDTH-1:1]};
            bout  <= nb;
            ovf   <= (x_msb ^ y_msb) & (d ^ x_msb);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes model results,
// monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   n_push = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .x    (x),
    .y    (y),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: unsigned and signed differences, range checks
  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic c);
    exp_t   e;
    longint ur;
    longint sr;
    ur = longint'(a) - longint'(b) - longint'(c);
    sr = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
    e.diff = W'(ur);
    e.bout = (ur < 0);
    e.ovf  = (sr > SMAX) || (sr < SMIN);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      chk("busy_with_done", longint'(busy), 0);
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got diff %0h want no result", diff);
      end else begin
        e = q.pop_front();
        chk("diff", longint'(diff), longint'(e.diff));
        chk("bout", longint'(bout), longint'(e.bout));
        chk("ovf",  longint'(ovf),  longint'(e.ovf));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    start = 1'b1;
    x     = a;
    y     = b;
    bin   = c;
    q.push_back(model(a, b, c));
    n_push++;
  endtask

  // One operation, optional stray start at RUN cycle inj (<0: none)
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic c, input int inj);
    issue(a, b, c);
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = W'($urandom);
    y     = W'($urandom);
    bin   = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_run", longint'(busy), 1);
      chk("done_early", longint'(done), 0);
      if (i == inj) begin
        start = 1'b1;
        x     = W'($urandom);
        y     = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_at_w", longint'(done), 1);
  endtask

  // Back-to-back burst with start held high throughout
  task automatic burst(input int n);
    issue(W'($urandom), W'($urandom), 1'($urandom));
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      x = W'($urandom);
      y = W'($urandom);
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        chk("b2b_busy", longint'(busy), 1);
        x   = W'($urandom);
        y   = W'($urandom);
        bin = 1'($urandom);
      end
      @(negedge clk);
      chk("b2b_done", longint'(done), 1);
      if (k < n - 1) issue(W'($urandom), W'($urandom), 1'($urandom));
      else start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_diff", longint'(diff), 0);
    chk("rst_bout", longint'(bout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    op(8'd100, 8'd37, 1'b0, -1);
    @(negedge clk);
    op(8'd5, 8'd9, 1'b0, -1);
    op(8'd0, 8'd0, 1'b1, -1);
    op(8'h80, 8'h01, 1'b0, -1);
    op(8'h7F, 8'hFF, 1'b0, -1);
    op(8'h80, 8'h00, 1'b1, -1);
    @(negedge clk);
    op(8'hA5, 8'h3C, 1'b0, 3);
    @(negedge clk);
    burst(4);
    @(negedge clk);

    // Abort mid-RUN: result 0x3F precedes, then reset at cycle 4
    op(8'd100, 8'd37, 1'b0, -1);
    @(negedge clk);
    chk("prior_diff", longint'(diff), 'h3F);
    start = 1'b1;
    x     = 8'd200;
    y     = 8'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_diff", longint'(diff), 0);
    chk("abort_bout", longint'(bout), 0);
    chk("abort_ovf",  longint'(ovf),  0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    chk("abort_idle", longint'(busy), 0);
    op(8'd77, 8'd200, 1'b1, -1);

    for (int r = 0; r < 40; r++) begin
      if (($urandom % 2) == 0) @(negedge clk);
      op(W'($urandom), W'($urandom), 1'($urandom),
         (($urandom % 3) == 0) ? int'($urandom_range(0, W - 2)) : -1);
    end
    burst(3);

    repeat (W + 4) @(negedge clk);
    chk("queue_drained", longint'(q.size()), 0);
    chk("done_count", longint'(n_done), longint'(n_push));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
